// File: rtl/proc_control.sv
// ---------------------------------------------------------------------------
// proc_control
//   Instruction-sequencing control unit for the general-purpose processor.
//   Latches a 9-bit instruction (III XXX YYY) from DIN in T0 and steps it
//   through time steps T0..T3. It drives the w/En inputs of the Rin and Rout
//   3-to-8 register-select decoders, plus the bus and ALU control strobes.
//
//   Opcodes (IR[8:6]): 000 mv Rx,Ry | 001 mvi Rx,#D | 010 add Rx,Ry |
//                      011 sub Rx,Ry | 100..111 NOP (or trap, see below)
//
// Ports
//   Clock   in   system clock, rising edge
//   Resetn  in   asynchronous active-low reset (clears step and IR)
//   Run     in   start strobe, sampled only in T0
//   DIN     in   instruction / immediate bus (bits above 8 ignored)
//   RinW    out  destination register index (Rin decoder w)
//   RinEn   out  Rin decoder enable
//   RoutW   out  source register index (Rout decoder w)
//   RoutEn  out  Rout decoder enable
//   IRin    out  IR load strobe
//   DINout  out  drive DIN onto the bus
//   Ain     out  load A register
//   Gin     out  load G register
//   Gout    out  drive G onto the bus
//   AddSub  out  ALU op: 0 = add, 1 = subtract
//   Done    out  one-cycle pulse on the final step of an instruction
//   Illegal out  (only with PROC_CONTROL_ILLEGAL_TRAP_EN) sticky trap flag
//
// Optional feature macro: PROC_CONTROL_ILLEGAL_TRAP_EN
//   When defined, opcodes 100..111 move the unit into a halt step TH and
//   raise Illegal; only Resetn=0 leaves TH. When undefined they are NOPs.
// ---------------------------------------------------------------------------
module proc_control #(
  parameter int DATA_W = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [2:0]        RinW,
  output logic              RinEn,
  output logic [2:0]        RoutW,
  output logic              RoutEn,
  output logic              IRin,
  output logic              DINout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              AddSub,
  output logic              Done
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic              Illegal
`endif
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // TH is only reachable when the illegal-opcode trap is built in.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    TH = 3'd4
  } tstep_t;

  tstep_t     tstep;
  tstep_t     tstep_next;
  logic [8:0] ir;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  // Time-step and instruction registers; IR only loads on a T0 start.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= T0;
      ir    <= 9'd0;
    end else begin
      tstep <= tstep_next;
      if ((tstep == T0) && Run) begin
        ir <= DIN[8:0];
      end else begin
        ir <= ir;
      end
    end
  end

  // Next-step and control-strobe decode for the current step and opcode.
  always_comb begin
    tstep_next = T0;
    RinW       = 3'd0;
    RinEn      = 1'b0;
    RoutW      = 3'd0;
    RoutEn     = 1'b0;
    IRin       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;
    case (tstep)
      T0: begin
        // Resetn is folded in so IRin stays low while reset is held.
        IRin = Run & Resetn;
        if (Run) begin
          tstep_next = T1;
        end else begin
          tstep_next = T0;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            RoutW      = ry;
            RoutEn     = 1'b1;
            RinW       = rx;
            RinEn      = 1'b1;
            Done       = 1'b1;
            tstep_next = T0;
          end
          OP_MVI: begin
            DINout     = 1'b1;
            RinW       = rx;
            RinEn      = 1'b1;
            Done       = 1'b1;
            tstep_next = T0;
          end
          OP_ADD, OP_SUB: begin
            RoutW      = rx;
            RoutEn     = 1'b1;
            Ain        = 1'b1;
            tstep_next = T2;
          end
          default: begin
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
            tstep_next = TH;
`else
            Done       = 1'b1;
            tstep_next = T0;
`endif
          end
        endcase
      end
      T2: begin
        // Only add/sub reach T2; IR[6] distinguishes sub from add.
        RoutW      = ry;
        RoutEn     = 1'b1;
        Gin        = 1'b1;
        AddSub     = ir[6];
        tstep_next = T3;
      end
      T3: begin
        Gout       = 1'b1;
        RinW       = rx;
        RinEn      = 1'b1;
        Done       = 1'b1;
        tstep_next = T0;
      end
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
      TH: begin
        tstep_next = TH;
      end
`endif
      default: begin
        tstep_next = T0;
      end
    endcase
  end

`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
  // The halt step itself is the sticky flag; reset is the only exit.
  assign Illegal = (tstep == TH);
`endif

endmodule

// File: doc/proc_control.md
Name: proc_control

Overview:
- Instruction-sequencing control unit for the general-purpose processor.
- Latches a 9-bit instruction (III XXX YYY) from DIN and steps it through time steps T0..T3.
- Drives the w/En inputs of the two downstream 3-to-8 register-select decoders (Rin and Rout), plus the bus and ALU control strobes.
- Sits directly upstream of those decoders.

Parameters:
DATA_W, 9, width of DIN; the instruction is DIN[8:0] and bits above 8 are ignored; must be >= 9.

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
Run  input  1  start strobe; sampled only in T0
DIN  input  DATA_W  instruction / immediate input bus
RinW  output  3  w input of the Rin decoder (destination register index)
RinEn  output  1  En of the Rin decoder
RoutW  output  3  w input of the Rout decoder (source register index)
RoutEn  output  1  En of the Rout decoder
IRin  output  1  IR load strobe (observability)
DINout  output  1  drive DIN onto the bus
Ain  output  1  load A register
Gin  output  1  load G register
Gout  output  1  drive G onto the bus
AddSub  output  1  ALU op: 0 = add, 1 = subtract
Done  output  1  one-cycle pulse on the final step of an instruction

Behaviour:
- State register: 2-bit time step Tstep in {T0, T1, T2, T3}. IR register: 9 bits. Both clear asynchronously on Resetn=0 (Tstep=T0, IR=0).
- Outputs are combinational from Tstep, IR and Run. Every output is 0 in all states unless listed below; RinW/RoutW are 0 when their En is 0.
- Reset: all outputs 0 while Resetn=0, including IRin regardless of Run.
- T0:
  - IRin = Run & Resetn.
  - If Run=1: IR <= DIN[8:0] at the clock edge; next state T1. Otherwise stay in T0.
- Opcodes (IR[8:6]): 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry; 011 sub Rx,Ry. X = IR[5:3], Y = IR[2:0].
- mv, T1: RoutW=Y, RoutEn=1, RinW=X, RinEn=1, Done=1 -> T0.
- mvi, T1: DINout=1, RinW=X, RinEn=1, Done=1 -> T0. The immediate is the DIN value in this cycle.
- add/sub:
  - T1: RoutW=X, RoutEn=1, Ain=1 -> T2.
  - T2: RoutW=Y, RoutEn=1, Gin=1, AddSub=IR[6] -> T3.
  - T3: Gout=1, RinW=X, RinEn=1, Done=1 -> T0.
- Opcodes 100..111 without the optional feature: NOP. T1 asserts only Done=1 -> T0.
- Latency: mv/mvi take 2 cycles including T0; add/sub take 4 cycles.
- Run and DIN are ignored outside T0; deasserting Run mid-instruction does not abort it.
- Back-to-back: Run held high gives a new IR load in the T0 immediately following Done; no idle cycle is required.
- Reset mid-instruction: immediate return to T0 with IR=0. No Done pulse is generated for the aborted instruction.
- X==Y is legal (e.g. add R3,R3); no special handling.
- RinEn and RoutEn are never both asserted with the same step's Gout/DINout conflict. At most one bus driver (RoutEn, DINout, Gout) is active per cycle; verification asserts this.

Optional Feature:
- Macro: PROC_CONTROL_ILLEGAL_TRAP_EN.
- When defined, an extra output port Illegal (1 bit) is added.
  - Opcode 100..111 in T1 sets a sticky Illegal=1 and moves to a halt state TH.
  - TH asserts no strobes, ignores Run, and is left only by Resetn=0, which clears Illegal.
- When undefined, the Illegal port does not exist and illegal opcodes execute as the NOP described above.

Test Plan:
- Reset: Resetn=0 with Run=1 -> all outputs 0; after release with Run=0, Tstep stays T0 for 5 cycles.
- mvi R2,#0x05 (DIN=9'b001_010_000, then DIN=5): T1 shows DINout=1, RinW=2, RinEn=1, Done=1; T0 follows.
- mv R5,R1 (DIN=9'b000_101_001) -> T1 shows RoutW=1, RoutEn=1, RinW=5, RinEn=1, Done=1.
- sub R0,R7 (9'b011_000_111) -> T1: RoutW=0, Ain=1; T2: RoutW=7, Gin=1, AddSub=1; T3: Gout=1, RinW=0, RinEn=1, Done=1. Repeat as add: AddSub=0.
- Resetn pulsed low during T2 of add -> outputs 0 immediately, no Done; the next Run loads a fresh instruction correctly.
- Opcode 111: NOP with Done in T1. With PROC_CONTROL_ILLEGAL_TRAP_EN: Illegal=1 and held through 10 cycles of Run=1, cleared by reset.
